// File: rtl/serial_load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_load_pkg
// Description : Shared types and defaults for the serial load transmitter,
//               its matching receiver and benches.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_load_pkg;

    localparam int c_data_width = 16;
    localparam int c_addr_width = 12;
    localparam int c_depth      = 2048;

    localparam logic [1:0] c_sram_sel_0 = 2'd0;
    localparam logic [1:0] c_sram_sel_1 = 2'd1;
    localparam logic [1:0] c_sram_sel_2 = 2'd2;
    localparam logic [1:0] c_sram_sel_3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/serial_piso_shifter.sv
`default_nettype none
// ============================================================================
// Module      : serial_piso_shifter
// Description : Parallel-load, MSB-first shift register (clear > load > shift).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_piso_shifter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] r_data;

    // Zero fill keeps the serial line low once a word has fully drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (clear) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= din;
        end else if (shift) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = r_data[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/serial_load_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : serial_load_transmitter
// Description : Frames parallel words into an MSB-first serial stream with
//               bit-valid strobe and held SRAM select.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_load_transmitter
    import serial_load_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DEPTH      = c_depth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            sram_sel_in,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  ser_data,
    output logic                  ser_load_en,
    output logic [1:0]            ser_sram_select,
    output logic                  busy,
    output logic                  done
);

    localparam int                    c_bit_w     = $clog2(DATA_WIDTH);
    localparam logic [c_bit_w-1:0]    c_last_bit  = c_bit_w'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_depth_cnt = ADDR_WIDTH'(DEPTH);

    state_e                  r_state;
    state_e                  w_next;
    logic [c_bit_w-1:0]      r_bit_cnt;
    logic [ADDR_WIDTH-1:0]   r_words_left;
    logic [ADDR_WIDTH-1:0]   w_count_clamped;
    logic                    w_last_bit;
    logic                    w_abort;
    logic                    w_ready;
    logic                    w_hs;
    logic                    w_shift;
    logic                    w_msb;
    logic                    r_load_en;
    logic                    r_busy;
    logic                    r_done;
    logic [1:0]              r_sel;

    assign w_count_clamped = (word_count > c_depth_cnt) ? c_depth_cnt : word_count;
    assign w_last_bit      = (r_bit_cnt == c_last_bit);
    assign w_abort         = abort && (r_state != ST_IDLE);
    // An aborted cycle never consumes the offered word.
    assign w_hs            = word_valid && w_ready && !w_abort;
    assign w_shift         = (r_state == ST_SHIFT) && !w_abort;

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_SETUP, ST_WAIT: w_ready = 1'b1;
            ST_SHIFT:          w_ready = w_last_bit && (r_words_left != '0);
            default:           w_ready = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (w_count_clamped == '0) ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP, ST_WAIT: begin
                if (w_hs) begin
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last_bit) begin
                    if (r_words_left == '0) begin
                        w_next = ST_DONE;
                    end else if (!w_hs) begin
                        w_next = ST_WAIT;
                    end
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_words_left <= '0;
        end else if (w_abort) begin
            r_bit_cnt    <= '0;
            r_words_left <= '0;
        end else begin
            if (r_state == ST_SHIFT) begin
                r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
            end
            if ((r_state == ST_IDLE) && start) begin
                r_words_left <= w_count_clamped;
            end else if (w_hs && (r_words_left != '0)) begin
                r_words_left <= r_words_left - ADDR_WIDTH'(1);
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sel     <= 2'd0;
        end else begin
            r_load_en <= (w_next == ST_SHIFT);
            r_busy    <= (w_next != ST_IDLE);
            r_done    <= (w_next == ST_DONE);
            if ((r_state == ST_IDLE) && start) begin
                r_sel <= sram_sel_in;
            end else if (w_next == ST_IDLE) begin
                r_sel <= 2'd0;
            end
        end
    end

    serial_piso_shifter #(
        .WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .clear (w_abort),
        .load  (w_hs),
        .shift (w_shift),
        .din   (word_in),
        .msb   (w_msb)
    );

    assign word_ready      = w_ready;
    assign ser_data        = w_msb;
    assign ser_load_en     = r_load_en;
    assign ser_sram_select = r_sel;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_load_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_load_transmitter
// Description : Directed self-checking bench for serial_load_transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_load_transmitter;
    import serial_load_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  sram_sel_in = 2'd0;
    logic [11:0] word_count = 12'd0;
    logic        abort = 1'b0;
    logic [15:0] word_in = 16'd0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        ser_data;
    logic        ser_load_en;
    logic [1:0]  ser_sram_select;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    serial_load_transmitter dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .sram_sel_in     (sram_sel_in),
        .word_count      (word_count),
        .abort           (abort),
        .word_in         (word_in),
        .word_valid      (word_valid),
        .word_ready      (word_ready),
        .ser_data        (ser_data),
        .ser_load_en     (ser_load_en),
        .ser_sram_select (ser_sram_select),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Line monitor: what the accelerator receiver would see.
    bit   q_bits[$];
    int   n_le = 0, n_rise = 0, n_done = 0;
    logic prev_le = 1'b0;
    always @(negedge clk) begin
        if (ser_load_en) begin
            q_bits.push_back(ser_data);
            n_le <= n_le + 1;
            if (!prev_le) n_rise <= n_rise + 1;
        end
        if (done) n_done <= n_done + 1;
        prev_le <= ser_load_en;
    end

    int s_le, s_rise, s_done, s_q;

    task automatic snap();
        s_le = n_le; s_rise = n_rise; s_done = n_done; s_q = q_bits.size();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] sel, input logic [11:0] cnt);
        start = 1'b1; sram_sel_in = sel; word_count = cnt;
        tick();
        start = 1'b0;
    endtask

    // Offer a word and hold it until it is taken.
    task automatic feed(input logic [15:0] w);
        logic ok;
        ok = 1'b0;
        word_in = w; word_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (word_ready) ok = 1'b1;
            tick();
        end
        word_valid = 1'b0;
        if (!ok) check("feed_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output logic [1:0] sel_at_done);
        logic seen;
        seen = 1'b0;
        sel_at_done = 2'd0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
                sel_at_done = ser_sram_select;
            end else begin
                tick();
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        tick();
    endtask

    function automatic logic [15:0] word_at(input int s);
        logic [15:0] w;
        w = 16'd0;
        for (int i = 0; i < 16; i++) w = {w[14:0], logic'(q_bits[s + i])};
        return w;
    endfunction

    logic [1:0] sel_d;

    initial begin
        // Reset state
        #2;
        check("rst_ser_data", ser_data, 0);
        check("rst_load_en", ser_load_en, 0);
        check("rst_sel", ser_sram_select, 0);
        check("rst_ready", word_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single word 0xA5C3 to SRAM 2
        snap();
        do_start(c_sram_sel_2, 12'd1);
        check("setup_sel", ser_sram_select, 2);
        check("setup_busy", busy, 1);
        check("setup_ready", word_ready, 1);
        check("setup_load_en", ser_load_en, 0);
        feed(16'hA5C3);
        check("first_bit_le", ser_load_en, 1);
        check("first_bit", ser_data, 1);
        check("shift_ready", word_ready, 0);
        wait_done(sel_d);
        check("t1_sel_done", sel_d, 2);
        check("t1_bits", word_at(s_q), 16'hA5C3);
        check("t1_le_cycles", n_le - s_le, 16);
        check("t1_le_runs", n_rise - s_rise, 1);
        check("t1_done_pulses", n_done - s_done, 1);
        check("t1_idle_sel", ser_sram_select, 0);
        check("t1_idle_busy", busy, 0);

        // Three back-to-back words
        snap();
        do_start(c_sram_sel_1, 12'd3);
        feed(16'h0001); feed(16'h8000); feed(16'hFFFF);
        wait_done(sel_d);
        check("t2_sel_done", sel_d, 1);
        check("t2_le_cycles", n_le - s_le, 48);
        check("t2_le_runs", n_rise - s_rise, 1);
        check("t2_w0", word_at(s_q), 16'h0001);
        check("t2_w1", word_at(s_q + 16), 16'h8000);
        check("t2_w2", word_at(s_q + 32), 16'hFFFF);

        // Underflow stall of five cycles between two words
        snap();
        do_start(c_sram_sel_3, 12'd2);
        feed(16'h1357);
        for (int i = 0; i < 16; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_wait_le", ser_load_en, 0);
            check("t3_wait_ready", word_ready, 1);
            if (i < 4) tick();
        end
        feed(16'h2468);
        wait_done(sel_d);
        check("t3_le_cycles", n_le - s_le, 32);
        check("t3_le_runs", n_rise - s_rise, 2);
        check("t3_w0", word_at(s_q), 16'h1357);
        check("t3_w1", word_at(s_q + 16), 16'h2468);

        // Zero-word frame
        snap();
        do_start(c_sram_sel_1, 12'd0);
        check("t4_done", done, 1);
        check("t4_busy", busy, 1);
        check("t4_le", ser_load_en, 0);
        tick();
        check("t4_done_low", done, 0);
        check("t4_idle_busy", busy, 0);
        check("t4_no_bits", n_le - s_le, 0);

        // Abort on bit 7 of word 2, then a clean frame
        snap();
        do_start(c_sram_sel_2, 12'd3);
        feed(16'h1234); feed(16'h5678); feed(16'h9ABC);
        for (int i = 0; i < 7; i++) tick();
        abort = 1'b1; word_valid = 1'b1; word_in = 16'hFFFF;
        tick();
        abort = 1'b0; word_valid = 1'b0;
        check("t5_abort_le", ser_load_en, 0);
        check("t5_abort_data", ser_data, 0);
        check("t5_abort_sel", ser_sram_select, 0);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_ready", word_ready, 0);
        tick(); tick();
        check("t5_no_done", n_done - s_done, 0);
        snap();
        do_start(c_sram_sel_3, 12'd1);
        feed(16'h0F0F);
        wait_done(sel_d);
        check("t5_post_sel", sel_d, 3);
        check("t5_post_bits", word_at(s_q), 16'h0F0F);
        check("t5_post_le", n_le - s_le, 16);

        // Asynchronous reset mid-shift, then a clean frame
        snap();
        do_start(c_sram_sel_2, 12'd2);
        feed(16'hFFFF);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("t6_rst_le", ser_load_en, 0);
        check("t6_rst_data", ser_data, 0);
        check("t6_rst_sel", ser_sram_select, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", word_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_no_done", n_done - s_done, 0);
        snap();
        do_start(c_sram_sel_1, 12'd1);
        feed(16'h3C5A);
        wait_done(sel_d);
        check("t6_post_bits", word_at(s_q), 16'h3C5A);
        check("t6_post_sel", sel_d, 1);

        // start during SHIFT is ignored
        snap();
        do_start(c_sram_sel_1, 12'd2);
        feed(16'hBEEF);
        tick(); tick(); tick(); tick();
        start = 1'b1; sram_sel_in = 2'd3; word_count = 12'd5;
        tick();
        start = 1'b0;
        check("t7_sel_held", ser_sram_select, 1);
        feed(16'hCAFE);
        wait_done(sel_d);
        check("t7_sel_done", sel_d, 1);
        check("t7_le_cycles", n_le - s_le, 32);
        check("t7_w0", word_at(s_q), 16'hBEEF);
        check("t7_w1", word_at(s_q + 16), 16'hCAFE);

        // Oversized count saturates to 2048 words
        snap();
        do_start(c_sram_sel_0, 12'd4095);
        for (int i = 0; i < 2048; i++) feed(16'(i * 16'h0101));
        wait_done(sel_d);
        check("t8_le_cycles", n_le - s_le, 2048 * 16);
        check("t8_le_runs", n_rise - s_rise, 1);
        check("t8_done_pulses", n_done - s_done, 1);
        check("t8_last_word", word_at(s_q + 2047 * 16), 16'(2047 * 16'h0101));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
